// File: rtl/uart_hex_reporter_if.sv
// Request and transmitter-handshake bundle for uart_hex_reporter.
interface uart_hex_reporter_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [7:0]        req_tag;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              busy;
    logic              frame_done;

    modport master (
        output req_valid, req_data, req_tag, tx_done,
        input  req_ready, tx_start, tx_data, busy, frame_done
    );

    modport slave (
        input  req_valid, req_data, req_tag, tx_done,
        output req_ready, tx_start, tx_data, busy, frame_done
    );
endinterface

// File: rtl/uart_hex_reporter.sv
// Formats a word (plus optional tag) as "T:HHHH..\r\n" and feeds it one byte at
// a time to a UART transmitter over the tx_start / tx_done handshake.
module uart_hex_reporter #(
    parameter int DATA_W    = 32,
    parameter int LOWER_HEX = 0
) (
    input  logic               clk,
    input  logic               reset,
    uart_hex_reporter_if.slave bus
);
    localparam int NIBBLES = DATA_W / 4;
    localparam int IDX_W   = $clog2(NIBBLES + 4);
    localparam logic [IDX_W-1:0] IDX_COLON = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_HEX0  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CR    = IDX_W'(NIBBLES + 2);
    localparam logic [IDX_W-1:0] IDX_LF    = IDX_W'(NIBBLES + 3);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        tag_q, tag_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              req_ready_q, req_ready_d;
    logic              frame_done_q, frame_done_d;
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  next_idx;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] alpha_base;
        alpha_base = (LOWER_HEX != 0) ? 8'h61 : 8'h41;
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return alpha_base + {4'h0, n} - 8'd10;
    endfunction

    // Character slots are fixed: 0 tag, 1 colon, hex digits, CR, LF.
    // Untagged frames simply start at the first hex slot.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0]  idx,
                                           input logic [DATA_W-1:0] data,
                                           input logic [7:0]        tag);
        logic [IDX_W-1:0]  pos;
        logic [DATA_W-1:0] shifted;
        if (idx == '0)        return tag;
        if (idx == IDX_COLON) return 8'h3A;
        if (idx == IDX_CR)    return 8'h0D;
        if (idx == IDX_LF)    return 8'h0A;
        pos     = IDX_CR - IDX_W'(1) - idx;
        shifted = data >> {pos, 2'b00};
        return hex_char(shifted[3:0]);
    endfunction

    assign first_idx = (bus.req_tag != 8'h00) ? '0 : IDX_HEX0;
    assign next_idx  = idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        tag_d        = tag_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        req_ready_d  = req_ready_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    data_d      = bus.req_data;
                    tag_d       = bus.req_tag;
                    idx_d       = first_idx;
                    tx_data_d   = char_at(first_idx, bus.req_data, bus.req_tag);
                    tx_start_d  = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (idx_q == IDX_LF) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        req_ready_d  = 1'b1;
                    end else begin
                        idx_d      = next_idx;
                        tx_data_d  = char_at(next_idx, data_q, tag_q);
                        tx_start_d = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            req_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            req_ready_q  <= req_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_hex_reporter.sv
// Randomized bench for uart_hex_reporter: upper- and lower-case instances run in
// lockstep against a queue-based model of the expected ASCII lines.
module tb_uart_hex_reporter;
    localparam int DATA_W = 32;
    localparam int NIB    = DATA_W / 4;
    localparam int TX_DLY = 5;
    localparam int BOUND  = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_done_m = 1'b0;
    logic tx_done_i = 1'b0;
    logic skip_lat = 1'b0;
    int   cyc = 0, frame_cnt = 0, frames_exp = 0, fd_cyc = -1, starts_total = 0;
    int   checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_l_q[$];

    uart_hex_reporter_if #(.DATA_W(DATA_W)) ifc();
    uart_hex_reporter_if #(.DATA_W(DATA_W)) ifc_l();

    assign ifc.tx_done     = tx_done_m | tx_done_i;
    assign ifc_l.tx_done   = ifc.tx_done;
    assign ifc_l.req_valid = ifc.req_valid;
    assign ifc_l.req_data  = ifc.req_data;
    assign ifc_l.req_tag   = ifc.req_tag;

    uart_hex_reporter #(.DATA_W(DATA_W), .LOWER_HEX(0)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave));
    uart_hex_reporter #(.DATA_W(DATA_W), .LOWER_HEX(1)) dut_l (
        .clk(clk), .reset(reset), .bus(ifc_l.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference line: tag and colon if tagged, every nibble MSB-first, CR LF.
    function automatic void push_frame(input logic [7:0] tag, input logic [DATA_W-1:0] data);
        if (tag != 8'h00) begin
            exp_q.push_back(tag);   exp_q.push_back(8'h3A);
            exp_l_q.push_back(tag); exp_l_q.push_back(8'h3A);
        end
        for (int i = NIB - 1; i >= 0; i--) begin
            int n;
            n = int'((data >> (4 * i)) & 32'hF);
            exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
            exp_l_q.push_back(n < 10 ? 8'(48 + n) : 8'(97 + n - 10));
        end
        exp_q.push_back(8'h0D);   exp_q.push_back(8'h0A);
        exp_l_q.push_back(8'h0D); exp_l_q.push_back(8'h0A);
    endfunction

    always @(negedge clk) begin
        if (ifc.tx_start) begin
            starts_total++;
            check_eq("start_expected", exp_q.size() != 0, 1'b1);
            check_eq("lower_lockstep", ifc_l.tx_start, 1'b1);
            if (exp_q.size() != 0)   check_eq("tx_byte", ifc.tx_data, exp_q.pop_front());
            if (exp_l_q.size() != 0) check_eq("tx_byte_lower", ifc_l.tx_data, exp_l_q.pop_front());
        end
        if (ifc.frame_done) begin
            frame_cnt++;
            fd_cyc = cyc;
        end
    end

    // Transmitter model: tx_done TX_DLY cycles after each tx_start.
    initial begin
        forever begin
            @(negedge clk);
            while (ifc.tx_start) begin
                for (int i = 0; i < TX_DLY - 1; i++) begin
                    @(negedge clk);
                    if (!skip_lat) check_eq("start_in_wait", ifc.tx_start, 1'b0);
                end
                @(negedge clk);
                tx_done_m = 1'b1;
                @(negedge clk);
                tx_done_m = 1'b0;
                if (!skip_lat) check_eq("next_start_lat", ifc.tx_start | ifc.frame_done, 1'b1);
            end
        end
    end

    task automatic send_req(input logic [7:0] tag, input logic [DATA_W-1:0] data, output int acc_cyc);
        int n;
        n = 0;
        push_frame(tag, data);
        frames_exp++;
        ifc.req_valid = 1'b1;
        ifc.req_tag   = tag;
        ifc.req_data  = data;
        while (!ifc.req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", ifc.req_ready, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        ifc.req_tag   = 8'($urandom);
        ifc.req_data  = $urandom;
        check_eq("first_start_lat", ifc.tx_start, 1'b1);
        check_eq("busy_on", ifc.busy, 1'b1);
        check_eq("ready_low", ifc.req_ready, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (frame_cnt < frames_exp && n < BOUND * 4) begin
            @(negedge clk);
            n++;
        end
        check_eq("frames_done", frame_cnt, frames_exp);
        @(negedge clk);
        check_eq("busy_after", ifc.busy, 1'b0);
        check_eq("ready_after", ifc.req_ready, 1'b1);
        check_eq("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, acc1, s0, cnt, n;
        logic [7:0] rtag;
        ifc.req_valid = 1'b0;
        ifc.req_data  = '0;
        ifc.req_tag   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", ifc.req_ready, 1'b0);
        check_eq("rst_start", ifc.tx_start, 1'b0);
        check_eq("rst_data", ifc.tx_data, 8'h00);
        check_eq("rst_busy", ifc.busy, 1'b0);
        check_eq("rst_fdone", ifc.frame_done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", ifc.req_ready, 1'b1);

        s0 = starts_total;
        send_req(8'h45, 32'hDEADBEEF, acc0);
        wait_done();
        check_eq("len_tagged", starts_total - s0, 12);
        check_eq("tx_data_hold", ifc.tx_data, 8'h0A);

        s0 = starts_total;
        send_req(8'h00, 32'h0000000A, acc0);
        wait_done();
        check_eq("len_untagged", starts_total - s0, 10);

        s0 = starts_total;
        send_req(8'h41, 32'hFFFFFFFF, acc0);
        wait_done();
        check_eq("len_lower", starts_total - s0, 12);

        // Spurious tx_done: one while idle, one during the third ISSUE cycle.
        tx_done_i = 1'b1;
        @(negedge clk);
        tx_done_i = 1'b0;
        @(negedge clk);
        check_eq("idle_stays_idle", ifc.busy, 1'b0);
        s0 = starts_total;
        send_req(8'h53, $urandom, acc0);
        cnt = 1;
        n = 0;
        while (cnt < 3 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (ifc.tx_start) cnt++;
        end
        tx_done_i = 1'b1;
        @(negedge clk);
        tx_done_i = 1'b0;
        wait_done();
        check_eq("len_spurious", starts_total - s0, 12);

        send_req(8'h42, $urandom, acc0);
        send_req(8'h00, $urandom, acc1);
        check_eq("b2b_accept", acc1, fd_cyc);
        wait_done();

        // Reset one cycle after the 4th character's tx_start.
        send_req(8'h52, $urandom, acc0);
        cnt = 1;
        n = 0;
        while (cnt < 4 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (ifc.tx_start) cnt++;
        end
        skip_lat = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_ready", ifc.req_ready, 1'b0);
        check_eq("abort_start", ifc.tx_start, 1'b0);
        check_eq("abort_busy", ifc.busy, 1'b0);
        check_eq("abort_data", ifc.tx_data, 8'h00);
        exp_q.delete();
        exp_l_q.delete();
        frames_exp--;
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_back", ifc.req_ready, 1'b1);
        s0 = starts_total;
        repeat (20) @(negedge clk);
        check_eq("abort_no_start", starts_total - s0, 0);
        skip_lat = 1'b0;
        s0 = starts_total;
        send_req(8'h45, 32'h12345678, acc0);
        wait_done();
        check_eq("len_after_abort", starts_total - s0, 12);

        for (int k = 0; k < 10; k++) begin
            rtag = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(33, 126)) : 8'h00;
            send_req(rtag, $urandom, acc0);
        end
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_hex_reporter.md
Name: uart_hex_reporter

Overview:
- Upstream feeder for the design's byte-serial UART transmitter.
- Accepts one binary word plus an optional ASCII tag per request, for example a DDR test error count or failing address.
- Formats the request as a fixed-width ASCII hex line: tag, ':', hex digits MSB-first, CR, LF.
- Sends that line to the transmitter one byte at a time, using the transmitter's tx_start / d_in / tx_done handshake.

Parameters:
- DATA_W, 32, width of the reported word. Must be a multiple of 4, range 4..64. NIBBLES = DATA_W/4.
- LOWER_HEX, 0, selects the letter case for hex digits A-F. 0 = uppercase (0x41-0x46), 1 = lowercase (0x61-0x66).

Ports:
- clk  in  1  system clock. Same clock as the UART transmitter and baud generator.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  a report request is present.
- req_ready  out  1  the block can accept a request.
- req_data  in  DATA_W  word to print.
- req_tag  in  8  ASCII tag character. 0x00 means no tag and no colon.
- tx_start  out  1  one-cycle pulse; the transmitter latches tx_data on this cycle.
- tx_data  out  8  character to transmit.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- busy  out  1  a frame is in progress (state is not IDLE).
- frame_done  out  1  one-cycle pulse after the final LF has completed.

Behaviour:
- Reset:
  - While reset=1, all of the following hold at the next edge: state=IDLE, req_ready=0, tx_start=0, tx_data=0x00, busy=0, frame_done=0, char index=0.
  - req_ready is registered. It becomes 1 on the first edge with reset=0.
  - Reset mid-frame aborts the frame immediately. No further tx_start is issued, and the remaining characters are discarded.
- Accept:
  - A request is accepted when req_valid && req_ready are both high at a rising edge.
  - At acceptance the block latches req_data and req_tag, and clears req_ready.
  - req_data and req_tag are don't-care after acceptance.
- Frame contents, in order:
  - If tag != 0x00: tag, then 0x3A (':').
  - NIBBLES hex characters, most significant nibble first.
  - 0x0D, then 0x0A.
  - Frame length is NIBBLES+4 with a tag and NIBBLES+2 without.
- Hex mapping:
  - n = 0..9 -> 0x30+n.
  - n = 10..15 -> 0x41+(n-10), or 0x61+(n-10) when LOWER_HEX=1.
  - Every digit is emitted; leading zeros are never suppressed.
- State machine IDLE / ISSUE / WAIT:
  - IDLE: on accept -> ISSUE, and the index is loaded with the first character.
  - ISSUE: tx_start=1 for exactly one cycle with tx_data valid -> WAIT.
  - WAIT: tx_data is held stable, tx_start=0. On tx_done:
    - If the index is the last character -> IDLE, frame_done=1 and req_ready=1 registered on that edge.
    - Otherwise the index increments -> ISSUE.
- Latency:
  - If the accept is at edge T, the first tx_start is high in cycle T+1.
  - If tx_done is high in cycle D, the next tx_start is high in cycle D+1. This lands exactly when the transmitter has returned to idle.
  - The final tx_done in cycle D gives frame_done and req_ready high in cycle D+1. An accept at that edge gives tx_start in D+2. Back-to-back frames therefore leave no extra gap.
- tx_start is never asserted while WAIT is pending a tx_done. Exactly one tx_start is issued per character.
- tx_done received in IDLE or ISSUE is ignored. It does not advance the index.
- tx_data holds its last value in IDLE.
- busy=1 in ISSUE and WAIT.
- There is no timeout. A missing tx_done stalls the block in WAIT indefinitely, and only reset exits.

Test Plan:
- DATA_W=32, tag 'E' (0x45), data 0xDEADBEEF -> exactly 12 tx_start pulses carrying 45 3A 44 45 41 44 42 45 45 46 0D 0A, then one frame_done pulse, and busy low afterwards.
- Tag 0x00, data 0x0000000A -> 10 bytes: 30 30 30 30 30 30 30 41 0D 0A. No colon is emitted.
- LOWER_HEX=1, tag 'A', data 0xFFFFFFFF -> digits are all 0x66, frame length 12.
- Transmitter model returns tx_done 5 cycles after each tx_start -> each next tx_start arrives exactly 1 cycle after tx_done. A second request held valid is accepted in the frame_done cycle, and its first tx_start follows one cycle later.
- Spurious tx_done pulse injected in IDLE, and another in the ISSUE cycle -> no index change, and the byte sequence is unchanged.
- Reset asserted for 1 cycle after the 4th character's tx_start -> no further tx_start, state IDLE. req_ready=0 during reset and 1 on the following cycle. A new request then produces its full frame from the first character.
